// File: rtl/inst_fetcher_pkg.sv
// ============================================================================
// Module : inst_fetcher_pkg
// Brief  : Shared fetch-stage constants, IQ entry layout and immediate helpers.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package inst_fetcher_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int OP_MSB         = 6;
  localparam int OP_LSB         = 0;
  localparam int IQ_ENTRY_WIDTH = DATA_WIDTH + DATA_WIDTH + 1;

  localparam logic [6:0] JAL_OP    = 7'b1101111;
  localparam logic [6:0] JALR_OP   = 7'b1100111;
  localparam logic [6:0] BRANCH_OP = 7'b1100011;

  localparam int FETCH_STATE_W = 2;
  localparam logic [FETCH_STATE_W-1:0] FETCH_IDLE    = 2'd0;
  localparam logic [FETCH_STATE_W-1:0] FETCH_WAIT    = 2'd1;
  localparam logic [FETCH_STATE_W-1:0] FETCH_DISCARD = 2'd2;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
    logic                  pred;
  } iq_entry_t;

  function automatic logic [DATA_WIDTH-1:0] j_imm(input logic [DATA_WIDTH-1:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] b_imm(input logic [DATA_WIDTH-1:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetcher_queue.sv
// ============================================================================
// Module : inst_queue
// Brief  : Power-of-two FIFO holding fetched instructions; clear beats push/pop.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_queue #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full && !clear;
  assign w_do_pop  = pop && !empty && !clear;
  assign rdata     = r_mem[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= r_tail;
      r_count <= '0;
    end else begin
      if (w_do_push) r_tail <= r_tail + PTR_W'(1);
      if (w_do_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_tail] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/inst_fetcher.sv
// ============================================================================
// Module : inst_fetcher
// Brief  : PC owner, single-outstanding fetch FSM, branch predictor and IQ.
//          Define FETCH_BHT_EN for a 2-bit BHT; otherwise static BTFN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                    IQ_DEPTH  = 4,
  parameter int                    BHT_IDX_W = 6,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  out_mem_req,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ready,
  input  logic [DATA_WIDTH-1:0] in_mem_inst,
  input  logic                  in_decode_ready,
  output logic                  out_inst_valid,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_current_pc,
  output logic                  out_predicted_taken,
  input  logic                  in_rob_mispredict,
  input  logic [DATA_WIDTH-1:0] in_rob_redirect_pc,
  input  logic                  in_bp_update_ena,
  input  logic [DATA_WIDTH-1:0] in_bp_update_pc,
  input  logic                  in_bp_update_taken
);

  logic [FETCH_STATE_W-1:0] r_state;
  logic [FETCH_STATE_W-1:0] w_state_next;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic [DATA_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    w_next_pc;
  logic [6:0]               w_opcode;
  logic                     w_pred;
  logic                     w_bp_taken;
  logic                     w_push;
  logic                     w_launch;
  logic                     w_pop_req;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_slot_free;
  iq_entry_t                w_wr_entry;
  iq_entry_t                w_head;
  logic [IQ_ENTRY_WIDTH-1:0] w_head_bits;

  assign w_opcode    = in_mem_inst[OP_MSB:OP_LSB];
  assign w_pop_req   = !w_empty && in_decode_ready;
  assign w_slot_free = !w_full || w_pop_req;
  assign w_wr_entry  = '{inst: in_mem_inst, pc: r_pc, pred: w_pred};
  assign w_head      = iq_entry_t'(w_head_bits);

`ifdef FETCH_BHT_EN
  logic [1:0]           r_bht [2**BHT_IDX_W];
  logic [BHT_IDX_W-1:0] w_upd_idx;
  logic                 w_unused_bht;

  assign w_upd_idx    = in_bp_update_pc[BHT_IDX_W+1:2];
  assign w_bp_taken   = r_bht[r_pc[BHT_IDX_W+1:2]][1];
  assign w_unused_bht = &{1'b0, in_bp_update_pc[DATA_WIDTH-1:BHT_IDX_W+2], in_bp_update_pc[1:0]};

  // Registered table: a same-cycle lookup of the updated index sees the old counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) r_bht[i] <= 2'b01;
    end else if (in_bp_update_ena) begin
      if (in_bp_update_taken && r_bht[w_upd_idx] != 2'b11)
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
      else if (!in_bp_update_taken && r_bht[w_upd_idx] != 2'b00)
        r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
    end
  end
`else
  logic w_unused_bp;

  // Backward-taken / forward-not-taken: the B immediate sign bit is inst[31].
  assign w_bp_taken  = in_mem_inst[31];
  assign w_unused_bp = &{1'b0, in_bp_update_ena, in_bp_update_pc, in_bp_update_taken,
                         (BHT_IDX_W > 0)};
`endif

  always_comb begin
    w_pred    = 1'b0;
    w_next_pc = r_pc + 32'd4;
    case (w_opcode)
      JAL_OP: begin
        w_pred    = 1'b1;
        w_next_pc = r_pc + j_imm(in_mem_inst);
      end
      JALR_OP: ; // target depends on a register, resolved downstream
      BRANCH_OP: begin
        if (w_bp_taken) begin
          w_pred    = 1'b1;
          w_next_pc = r_pc + b_imm(in_mem_inst);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE:    if (!in_rob_mispredict && w_slot_free) w_state_next = FETCH_WAIT;
      FETCH_WAIT:    if (in_mem_ready) w_state_next = FETCH_IDLE;
                     else if (in_rob_mispredict) w_state_next = FETCH_DISCARD;
      FETCH_DISCARD: if (in_mem_ready) w_state_next = FETCH_IDLE;
      default:       w_state_next = FETCH_IDLE;
    endcase
  end

  always_comb begin
    out_mem_req = 1'b0;
    w_push      = 1'b0;
    w_launch    = 1'b0;
    case (r_state)
      FETCH_IDLE:    w_launch    = (w_state_next == FETCH_WAIT);
      FETCH_WAIT: begin
        out_mem_req = 1'b1;
        w_push      = in_mem_ready && !in_rob_mispredict;
      end
      FETCH_DISCARD: out_mem_req = 1'b1;
      default: ;
    endcase
  end

  // r_addr freezes the bus address so a redirect cannot disturb an open request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RESET_PC;
      r_addr <= '0;
    end else begin
      if (in_rob_mispredict) r_pc <= in_rob_redirect_pc;
      else if (w_push)       r_pc <= w_next_pc;
      if (w_launch) r_addr <= r_pc;
    end
  end

  assign out_mem_addr = r_addr;

  inst_queue #(
    .WIDTH (IQ_ENTRY_WIDTH),
    .DEPTH (IQ_DEPTH)
  ) u_inst_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop_req && !in_rob_mispredict),
    .clear (in_rob_mispredict),
    .wdata (w_wr_entry),
    .rdata (w_head_bits),
    .full  (w_full),
    .empty (w_empty)
  );

  assign out_inst_valid      = !w_empty;
  assign out_inst            = w_empty ? '0 : w_head.inst;
  assign out_current_pc      = w_empty ? '0 : w_head.pc;
  assign out_predicted_taken = !w_empty && w_head.pred;

endmodule

`default_nettype wire
